note_lane_ctrl: RTL and testbench
=================================

Name: note_lane_ctrl

Overview:
- Per-lane note controller for the rhythm game.
- Spawns a falling note on request and advances it through bar states 1..7 at a fixed step rate.
- Judges the player's key press against a hit window, then returns to idle.
- Its 3-bit `state` output drives the lane's 7-segment bar decoder directly: 0 = bar dark, 7 = fully lit. It also emits hit/miss pulses and a combo count to the score logic.

Parameters:
- STEP_DIV, 5000000, clock cycles per bar state (100 ms at 50 MHz); legal range 2..2^24-1.
- WIN_LO, 6, lowest state inside the hit window; legal range 1..7. The window is WIN_LO..7.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- note_req  input  1  one-cycle pulse requesting a new note on this lane
- key  input  1  debounced lane key level, 1 = pressed
- state  output  3  bar position to the segment decoder; 0 = idle, 1..7 = note falling
- busy  output  1  high whenever state != 0
- hit  output  1  one-cycle pulse, correct press
- miss  output  1  one-cycle pulse, early press or note expired
- drop  output  1  one-cycle pulse, note_req discarded
- combo  output  8  consecutive-hit count, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - state=0, busy=0, hit=0, miss=0, drop=0, combo=0.
  - Prescaler=0, pending=0, key_d=1. key_d resets to 1 so a key held through reset is not a press.
  - Asserting rst mid-note clears everything immediately; no pulse is emitted.
- Key edge: `press = key & ~key_d`. key_d is registered every cycle.
- Prescaler:
  - Counts 0..STEP_DIV-1 only while state != 0.
  - `tick` = prescaler == STEP_DIV-1; on tick the prescaler wraps to 0.
  - Forced to 0 on spawn and on return to idle.
- IDLE (state 0):
  - If note_req or pending is set, go to state 1 at the next edge and clear pending (spawn).
  - press in IDLE is ignored: no pulse, combo unchanged.
- FALL (state 1..WIN_LO-1):
  - press → state←0, miss=1, combo←0 (early press).
  - Otherwise tick → state+1.
- WINDOW (state WIN_LO..7):
  - press → state←0, hit=1, combo←min(combo+1, 255).
  - Otherwise, tick in state 7 → state←0, miss=1, combo←0 (expired).
  - Otherwise tick → state+1.
- Each state 1..7 lasts exactly STEP_DIV cycles absent a press. Spawn to expiry takes 7*STEP_DIV cycles.
- Simultaneous events:
  - press and tick in the same cycle: the press is judged against the current state; the tick is ignored.
  - press in state WIN_LO-1 coinciding with the tick into WIN_LO is judged early (miss).
- Queueing:
  - note_req while state != 0 → pending←1 if pending=0.
  - note_req while pending=1 already → drop=1, pending unchanged.
  - note_req in the cycle a note terminates is captured into pending. The new note spawns one cycle after state reaches 0, so state is 0 for exactly one cycle between notes.
- Outputs are registered:
  - hit/miss/drop assert in the same cycle state becomes 0 (or the request is dropped), for one cycle.
  - hit and miss are mutually exclusive.
  - busy = (state != 0), combinational from the state register.
- Saturation: combo holds at 255 on further hits.

Test Plan:
- STEP_DIV=4, WIN_LO=6; note_req at cycle 0, no key → state 1 for cycles 1-4, 2 for cycles 5-8, …, 7 for cycles 25-28; state=0 and miss=1 at cycle 29; combo=0.
- Same spawn, key rises at cycle 22 (state 6) → hit=1 and state=0 at cycle 23; combo=1. Repeat 3 notes → combo=3. Then an expired note → combo=0.
- Key rises at cycle 10 (state 3) → miss=1, state=0 at cycle 11. Key rise in idle → no pulse, state stays 0.
- note_req at cycles 0, 3, 6 → second is held pending, third gives drop=1 at cycle 7. After the first note ends, state=0 for one cycle, then state=1.
- Key held high through reset release → no hit/miss. Force combo to 255 via 256 hits → stays 255. Assert rst while state=4 → all outputs 0 immediately, no pulse.
- Key rise in the same cycle as the state 5→6 tick → miss (early), state=0.

Source files
------------

// File: rtl/note_lane_if.sv
// Lane-side bundle for note_lane_ctrl: request/key inputs from the game
// and bar/score outputs.
interface note_lane_if;
   logic       note_req;
   logic       key;
   logic [2:0] state;
   logic       busy;
   logic       hit;
   logic       miss;
   logic       drop;
   logic [7:0] combo;

   // master = game/score side, slave = the lane controller
   modport master (
      output note_req, key,
      input  state, busy, hit, miss, drop, combo
   );

   modport slave (
      input  note_req, key,
      output state, busy, hit, miss, drop, combo
   );
endinterface

// File: rtl/note_lane_ctrl.sv
// Per-lane note controller: spawns a falling note, steps it through bar
// states 1..7, judges the key press against the hit window, keeps the combo.
module note_lane_ctrl #(
   parameter int unsigned STEP_DIV = 5000000,
   parameter int unsigned WIN_LO   = 6
) (
   input  logic        clk,
   input  logic        rst,
   note_lane_if.slave  bus
);

   localparam logic [2:0]  ST_IDLE = 3'd0;
   localparam logic [2:0]  ST_LAST = 3'd7;
   localparam logic [2:0]  WIN_ST  = 3'(WIN_LO);
   localparam logic [23:0] TICK_AT = 24'(STEP_DIV - 1);

   logic [2:0]  state;
   logic [23:0] prescale;
   logic        pending;
   logic        key_d;
   logic        hit;
   logic        miss;
   logic        drop;
   logic [7:0]  combo;

   logic active;
   logic press;
   logic tick;
   logic in_window;
   logic good_press;
   logic early_press;
   logic expire;
   logic advance;
   logic spawn;

   // A press is judged before the tick, so a press on the tick edge
   // belongs to the state being left.
   always_comb begin
      active      = (state != ST_IDLE);
      press       = bus.key & ~key_d;
      tick        = active && (prescale == TICK_AT);
      in_window   = (state >= WIN_ST);
      good_press  = active & press & in_window;
      early_press = active & press & ~in_window;
      expire      = tick & ~press & (state == ST_LAST);
      advance     = tick & ~press & (state != ST_LAST);
      spawn       = ~active & (bus.note_req | pending);
   end

   // key_d resets high so a key held through reset never counts as a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_d <= 1'b1;
      end else begin
         key_d <= bus.key;
      end
   end

   // Step prescaler: free-runs only while a note is falling and restarts
   // at every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
      end else if (!active || press || tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + 24'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (spawn) begin
         state <= 3'd1;
      end else if (good_press || early_press || expire) begin
         state <= ST_IDLE;
      end else if (advance) begin
         state <= state + 3'd1;
      end
   end

   // One-deep request queue. A request arriving in idle while a queued one
   // is spawning takes over the freed slot instead of being dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         drop    <= 1'b0;
      end else begin
         drop <= active & bus.note_req & pending;
         if (!active) begin
            pending <= pending & bus.note_req;
         end else if (bus.note_req) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit   <= 1'b0;
         miss  <= 1'b0;
         combo <= '0;
      end else begin
         hit  <= good_press;
         miss <= early_press | expire;
         if (good_press) begin
            if (combo != 8'hFF) begin
               combo <= combo + 8'd1;
            end
         end else if (early_press || expire) begin
            combo <= '0;
         end
      end
   end

   assign bus.state = state;
   assign bus.busy  = (state != ST_IDLE);
   assign bus.hit   = hit;
   assign bus.miss  = miss;
   assign bus.drop  = drop;
   assign bus.combo = combo;

endmodule

// File: tb/tb_note_lane_ctrl.sv
// Self-checking bench for note_lane_ctrl with STEP_DIV=4, WIN_LO=6:
// a table of single-note scenarios plus hand-written queue/reset sequences.
module tb_note_lane_ctrl;

   localparam int STEP = 4;
   localparam int WIN  = 6;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   note_lane_if bus ();

   note_lane_ctrl #(.STEP_DIV(STEP), .WIN_LO(WIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   keyAt;
      logic expHit;
      logic expMiss;
      int   expEnd;
      int   expCombo;
   } vec_t;

   vec_t vecs[8];

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs and land #1 after the next rising edge.
   task automatic applyStimulus(input logic req, input logic k);
      bus.note_req = req;
      bus.key      = k;
      @(posedge clk);
      #1;
   endtask

   function automatic int expState(input int n);
      return (n - 1) / STEP + 1;
   endfunction

   // Spawn at cycle 0, key rises at keyAt and stays high until the note ends.
   task automatic playNote(input int keyAt, output int endCycle, output logic sawHit,
                           output logic sawMiss, output int endState, output int endCombo);
      endCycle = -1;
      sawHit   = 1'b0;
      sawMiss  = 1'b0;
      endState = -1;
      endCombo = -1;
      for (int c = 0; c < 40 && endCycle < 0; c++) begin
         applyStimulus(c == 0, c >= keyAt);
         if (bus.hit || bus.miss) begin
            endCycle = c + 1;
            sawHit   = bus.hit;
            sawMiss  = bus.miss;
            endState = int'(bus.state);
            endCombo = int'(bus.combo);
         end else begin
            checkOutput("fall_state", int'(bus.state), expState(c + 1));
         end
      end
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      int   endCycle;
      logic sawHit;
      logic sawMiss;
      int   endState;
      int   endCombo;
      int   hits;
      logic anyPulse;

      compared   = 0;
      mismatched = 0;

      vecs[0] = '{keyAt: 22, expHit: 1'b1, expMiss: 1'b0, expEnd: 23, expCombo: 1};
      vecs[1] = '{keyAt: 24, expHit: 1'b1, expMiss: 1'b0, expEnd: 25, expCombo: 2};
      vecs[2] = '{keyAt: 28, expHit: 1'b1, expMiss: 1'b0, expEnd: 29, expCombo: 3};
      vecs[3] = '{keyAt: 99, expHit: 1'b0, expMiss: 1'b1, expEnd: 29, expCombo: 0};
      vecs[4] = '{keyAt: 21, expHit: 1'b1, expMiss: 1'b0, expEnd: 22, expCombo: 1};
      vecs[5] = '{keyAt: 20, expHit: 1'b0, expMiss: 1'b1, expEnd: 21, expCombo: 0};
      vecs[6] = '{keyAt: 26, expHit: 1'b1, expMiss: 1'b0, expEnd: 27, expCombo: 1};
      vecs[7] = '{keyAt: 10, expHit: 1'b0, expMiss: 1'b1, expEnd: 11, expCombo: 0};

      // Reset with the key already held down.
      rst          = 1'b1;
      bus.note_req = 1'b0;
      bus.key      = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_state", int'(bus.state), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_hit", int'(bus.hit), 0);
      checkOutput("rst_miss", int'(bus.miss), 0);
      checkOutput("rst_drop", int'(bus.drop), 0);
      checkOutput("rst_combo", int'(bus.combo), 0);
      rst = 1'b0;

      anyPulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1);
         anyPulse = anyPulse | bus.hit | bus.miss;
      end
      checkOutput("held_key_pulse", int'(anyPulse), 0);
      applyStimulus(1'b0, 1'b0);

      // Key rise while idle is ignored.
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_press_state", int'(bus.state), 0);
      checkOutput("idle_press_pulse", int'(bus.hit | bus.miss), 0);
      checkOutput("idle_press_combo", int'(bus.combo), 0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);

      for (int v = 0; v < 8; v++) begin
         playNote(vecs[v].keyAt, endCycle, sawHit, sawMiss, endState, endCombo);
         checkOutput($sformatf("vec%0d_end", v), endCycle, vecs[v].expEnd);
         checkOutput($sformatf("vec%0d_hit", v), int'(sawHit), int'(vecs[v].expHit));
         checkOutput($sformatf("vec%0d_miss", v), int'(sawMiss), int'(vecs[v].expMiss));
         checkOutput($sformatf("vec%0d_state", v), endState, 0);
         checkOutput($sformatf("vec%0d_combo", v), endCombo, vecs[v].expCombo);
      end
      checkOutput("after_table_busy", int'(bus.busy), 0);

      // Requests at cycles 0, 3, 6: second queued, third dropped.
      for (int c = 0; c < 30; c++) begin
         applyStimulus(c == 0 || c == 3 || c == 6, 1'b0);
         checkOutput($sformatf("queue_drop_c%0d", c + 1), int'(bus.drop), int'(c + 1 == 7));
         if (c + 1 == 29) begin
            checkOutput("queue_gap_state", int'(bus.state), 0);
            checkOutput("queue_gap_busy", int'(bus.busy), 0);
            checkOutput("queue_gap_miss", int'(bus.miss), 1);
         end
         if (c + 1 == 30) begin
            checkOutput("queue_respawn_state", int'(bus.state), 1);
         end
      end
      sawMiss = 1'b0;
      for (int c = 0; c < 32; c++) begin
         applyStimulus(1'b0, 1'b0);
         sawMiss = sawMiss | bus.miss;
      end
      checkOutput("queue_second_expired", int'(sawMiss), 1);
      checkOutput("queue_no_third", int'(bus.state), 0);

      // Combo saturates at 255.
      hits = 0;
      for (int n = 0; n < 256; n++) begin
         playNote(22, endCycle, sawHit, sawMiss, endState, endCombo);
         if (sawHit) hits++;
         if (n == 254) checkOutput("combo_255", endCombo, 255);
      end
      checkOutput("combo_hits", hits, 256);
      checkOutput("combo_sat", int'(bus.combo), 255);

      // Asynchronous reset while the bar shows 4.
      applyStimulus(1'b1, 1'b0);
      for (int c = 0; c < 12; c++) applyStimulus(1'b0, 1'b0);
      checkOutput("pre_rst_state", int'(bus.state), 4);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_state", int'(bus.state), 0);
      checkOutput("async_rst_busy", int'(bus.busy), 0);
      checkOutput("async_rst_combo", int'(bus.combo), 0);
      checkOutput("async_rst_pulse", int'(bus.hit | bus.miss | bus.drop), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      anyPulse = 1'b0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b0);
         anyPulse = anyPulse | bus.hit | bus.miss | bus.drop;
      end
      checkOutput("post_rst_pulse", int'(anyPulse), 0);
      checkOutput("post_rst_state", int'(bus.state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
